// File: rtl/multicycle_main_ctrl.sv
// Multi-cycle main control FSM for the SPU datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes and the 4-bit ALUctr, and traps on illegal op, overflow or bus timeout.
module multicycle_main_ctrl #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_of,
    output logic [3:0]  ALUctr,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_sign,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        tgt_we,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        trap,
    output logic [1:0]  trap_cause
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    localparam logic [3:0] A_ADD  = 4'h0, A_ADDU = 4'h1, A_SUB = 4'h2, A_SUBU = 4'h3,
                           A_AND  = 4'h4, A_OR   = 4'h5, A_XOR = 4'h6, A_NOR  = 4'h7,
                           A_SLT  = 4'h8, A_SLTU = 4'h9, A_LUI = 4'hA;
    localparam logic [5:0] OP_R  = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [1:0] C_ILL = 2'b01, C_OVF = 2'b10, C_TMO = 2'b11;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       cause_q, cause_d;

    logic [5:0]  op, funct;
    logic        is_r, is_imm, is_ld, is_st, is_br, is_j, legal, ov_class;
    logic [3:0]  ex_alu;
    logic [1:0]  ex_src_b;
    logic        ex_ext;
    logic        tmo_hit;
    logic [19:0] unused_fields;

    assign op            = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = instr[25:6];

    // Instruction class and the ALU setup it needs in EXEC (and holds through MEM).
    always_comb begin
        is_r   = (op == OP_R);
        is_imm = (op[5:3] == 3'b001);
        is_ld  = (op == OP_LW);
        is_st  = (op == OP_SW);
        is_br  = (op == OP_BEQ) || (op == OP_BNE);
        is_j   = (op == OP_J);
        legal  = 1'b1;
        ex_alu = A_ADDU;
        ex_ext = is_ld || is_st;
        if (is_r) begin
            case (funct)
                6'h20:   ex_alu = A_ADD;
                6'h21:   ex_alu = A_ADDU;
                6'h22:   ex_alu = A_SUB;
                6'h23:   ex_alu = A_SUBU;
                6'h24:   ex_alu = A_AND;
                6'h25:   ex_alu = A_OR;
                6'h26:   ex_alu = A_XOR;
                6'h27:   ex_alu = A_NOR;
                6'h2A:   ex_alu = A_SLT;
                6'h2B:   ex_alu = A_SLTU;
                default: legal  = 1'b0;
            endcase
        end else if (is_imm) begin
            case (op[2:0])
                3'd0: ex_alu = A_ADD;
                3'd1: ex_alu = A_ADDU;
                3'd2: ex_alu = A_SLT;
                3'd3: ex_alu = A_SLTU;
                3'd4: ex_alu = A_AND;
                3'd5: ex_alu = A_OR;
                3'd6: ex_alu = A_XOR;
                3'd7: ex_alu = A_LUI;
            endcase
            // arithmetic/compare immediates sign-extend, logical ones zero-extend
            ex_ext = ~op[2];
        end else if (is_br) begin
            ex_alu = A_SUBU;
        end else if (!(is_ld || is_st || is_j)) begin
            legal = 1'b0;
        end
        ex_src_b = (is_r || is_br) ? 2'b00 : 2'b10;
        ov_class = (ex_alu == A_ADD) || (ex_alu == A_SUB);
    end

    assign tmo_hit = !mem_ready && (tmo_q == TMO_W'(TMO_MAX - 1));

    always_comb begin
        state_d    = state_q;
        tmo_d      = '0;
        cause_d    = cause_q;
        ALUctr     = 4'h0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_sign   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        tgt_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                ALUctr    = A_ADDU;
                alu_src_b = 2'b01;
                mem_req   = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = C_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_TRAP;
                    cause_d = C_ILL;
                end else begin
                    ALUctr    = A_ADDU;
                    alu_src_b = 2'b11;
                    ext_sign  = 1'b1;
                    tgt_we    = 1'b1;
                    if (is_j) begin
                        pc_we   = 1'b1;
                        pc_src  = 2'b10;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                ALUctr    = ex_alu;
                alu_src_a = 1'b1;
                alu_src_b = ex_src_b;
                ext_sign  = ex_ext;
                if (is_br) begin
                    pc_src  = 2'b01;
                    pc_we   = alu_zero ^ (op == OP_BNE);
                    state_d = S_FETCH;
                end else if (alu_of && ov_class) begin
                    state_d = S_TRAP;
                    cause_d = C_OVF;
                end else begin
                    state_d = (is_ld || is_st) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                ALUctr    = ex_alu;
                alu_src_a = 1'b1;
                alu_src_b = ex_src_b;
                ext_sign  = ex_ext;
                mem_req   = 1'b1;
                mem_we    = is_st;
                if (mem_ready) begin
                    state_d = is_st ? S_FETCH : S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = C_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_ld;
                state_d    = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign trap_cause = cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cause_q <= cause_d;
        end
    end
endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Bench for multicycle_main_ctrl: EXEC decode vector table, directed multi-cycle sequences,
// and random instruction streams checked against a per-phase strobe model.
module tb_multicycle_main_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0, alu_zero = 1'b0, alu_of = 1'b0;
    logic [3:0]  ALUctr;
    logic        alu_src_a, ext_sign, mem_req, mem_we, ir_we, pc_we, tgt_we;
    logic        reg_we, reg_dst, mem_to_reg, trap;
    logic [1:0]  alu_src_b, pc_src, trap_cause;

    multicycle_main_ctrl #(.TMO_W(8), .TMO_MAX(255)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_of(alu_of), .ALUctr(ALUctr), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_sign(ext_sign), .mem_req(mem_req), .mem_we(mem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .tgt_we(tgt_we), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] alu; logic sa; logic [1:0] sb; logic ext; logic req; logic we;
        logic irwe; logic pcwe; logic [1:0] pcsrc; logic tgt; logic regwe; logic rdst;
        logic m2r; logic trp; logic [1:0] cause;
    } obs_t;

    typedef struct {
        logic [31:0] ins; logic z; obs_t exp;
    } vec_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6;
    typedef struct {
        logic [5:0] op; logic [5:0] fn; int kind; logic [3:0] alu; logic [1:0] sb; logic ext;
    } idef_t;

    obs_t  act;
    int    n_cmp = 0, n_bad = 0;
    vec_t  vt[$];
    idef_t defs[$];

    assign act = {ALUctr, alu_src_a, alu_src_b, ext_sign, mem_req, mem_we, ir_we, pc_we,
                  pc_src, tgt_we, reg_we, reg_dst, mem_to_reg, trap, trap_cause};

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // Called at posedge+1: apply inputs, compare at the falling edge, advance one cycle.
    task automatic step(input string name, input logic mr, input logic z, input logic of,
                        input obs_t exp);
        mem_ready = mr; alu_zero = z; alu_of = of;
        @(negedge clk);
        check(name, act, exp);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #2;
        check(name, act, obs_t'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    function automatic obs_t o_fetch(input logic r);
        obs_t o = '0;
        o.alu = 4'h1; o.sb = 2'b01; o.req = 1'b1; o.irwe = r; o.pcwe = r;
        return o;
    endfunction

    function automatic obs_t o_decode(input logic j);
        obs_t o = '0;
        o.alu = 4'h1; o.sb = 2'b11; o.ext = 1'b1; o.tgt = 1'b1;
        if (j) begin o.pcwe = 1'b1; o.pcsrc = 2'b10; end
        return o;
    endfunction

    function automatic obs_t mk(input logic [3:0] alu, input logic [1:0] sb, input logic ext,
                                input logic pcwe, input logic [1:0] pcsrc);
        obs_t o = '0;
        o.alu = alu; o.sa = 1'b1; o.sb = sb; o.ext = ext; o.pcwe = pcwe; o.pcsrc = pcsrc;
        return o;
    endfunction

    function automatic obs_t o_exec(input idef_t d, input logic z);
        obs_t o = mk(d.alu, d.sb, d.ext, 1'b0, 2'b00);
        if (d.kind == K_BEQ || d.kind == K_BNE) begin
            o.pcsrc = 2'b01;
            o.pcwe  = z ^ (d.kind == K_BNE);
        end
        return o;
    endfunction

    function automatic obs_t o_mem(input idef_t d);
        obs_t o = o_exec(d, 1'b0);
        o.req = 1'b1; o.we = (d.kind == K_SW);
        return o;
    endfunction

    function automatic obs_t o_wb(input logic rdst, input logic m2r);
        obs_t o = '0;
        o.regwe = 1'b1; o.rdst = rdst; o.m2r = m2r;
        return o;
    endfunction

    function automatic obs_t o_trap(input logic [1:0] c);
        obs_t o = '0;
        o.trp = 1'b1; o.cause = c;
        return o;
    endfunction

    function automatic int find_def(input logic [31:0] ins);
        for (int i = 0; i < defs.size(); i++)
            if (defs[i].op == ins[31:26] && (defs[i].kind != K_R || defs[i].fn == ins[5:0]))
                return i;
        return -1;
    endfunction

    task automatic add_def(input logic [5:0] op, input logic [5:0] fn, input int kind,
                           input logic [3:0] alu, input logic [1:0] sb, input logic ext);
        idef_t d;
        d.op = op; d.fn = fn; d.kind = kind; d.alu = alu; d.sb = sb; d.ext = ext;
        defs.push_back(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ill [5];
        idef_t d;
        int    cnt;

        // EXEC-phase decode table (instruction, alu_zero, expected EXEC outputs)
        vt.push_back('{32'h00221820, 1'b0, mk(4'h0, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h00221821, 1'b0, mk(4'h1, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h00221822, 1'b0, mk(4'h2, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h00221823, 1'b0, mk(4'h3, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h00221824, 1'b0, mk(4'h4, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h00221825, 1'b0, mk(4'h5, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h00221826, 1'b0, mk(4'h6, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h00221827, 1'b0, mk(4'h7, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h0022182A, 1'b0, mk(4'h8, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h0022182B, 1'b0, mk(4'h9, 2'b00, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h20220005, 1'b0, mk(4'h0, 2'b10, 1'b1, 1'b0, 2'b00)});
        vt.push_back('{32'h24220005, 1'b0, mk(4'h1, 2'b10, 1'b1, 1'b0, 2'b00)});
        vt.push_back('{32'h28220005, 1'b0, mk(4'h8, 2'b10, 1'b1, 1'b0, 2'b00)});
        vt.push_back('{32'h2C220005, 1'b0, mk(4'h9, 2'b10, 1'b1, 1'b0, 2'b00)});
        vt.push_back('{32'h30220005, 1'b0, mk(4'h4, 2'b10, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h34220005, 1'b0, mk(4'h5, 2'b10, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h38220005, 1'b0, mk(4'h6, 2'b10, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h3C020005, 1'b0, mk(4'hA, 2'b10, 1'b0, 1'b0, 2'b00)});
        vt.push_back('{32'h8C220008, 1'b0, mk(4'h1, 2'b10, 1'b1, 1'b0, 2'b00)});
        vt.push_back('{32'hAC220004, 1'b0, mk(4'h1, 2'b10, 1'b1, 1'b0, 2'b00)});
        vt.push_back('{32'h10220003, 1'b1, mk(4'h3, 2'b00, 1'b0, 1'b1, 2'b01)});
        vt.push_back('{32'h10220003, 1'b0, mk(4'h3, 2'b00, 1'b0, 1'b0, 2'b01)});
        vt.push_back('{32'h14220003, 1'b1, mk(4'h3, 2'b00, 1'b0, 1'b0, 2'b01)});
        vt.push_back('{32'h14220003, 1'b0, mk(4'h3, 2'b00, 1'b0, 1'b1, 2'b01)});

        // legal instruction set for the random model
        add_def(6'h00, 6'h20, K_R, 4'h0, 2'b00, 1'b0); add_def(6'h00, 6'h21, K_R, 4'h1, 2'b00, 1'b0);
        add_def(6'h00, 6'h22, K_R, 4'h2, 2'b00, 1'b0); add_def(6'h00, 6'h23, K_R, 4'h3, 2'b00, 1'b0);
        add_def(6'h00, 6'h24, K_R, 4'h4, 2'b00, 1'b0); add_def(6'h00, 6'h25, K_R, 4'h5, 2'b00, 1'b0);
        add_def(6'h00, 6'h26, K_R, 4'h6, 2'b00, 1'b0); add_def(6'h00, 6'h27, K_R, 4'h7, 2'b00, 1'b0);
        add_def(6'h00, 6'h2A, K_R, 4'h8, 2'b00, 1'b0); add_def(6'h00, 6'h2B, K_R, 4'h9, 2'b00, 1'b0);
        add_def(6'h08, 6'h00, K_I, 4'h0, 2'b10, 1'b1); add_def(6'h09, 6'h00, K_I, 4'h1, 2'b10, 1'b1);
        add_def(6'h0A, 6'h00, K_I, 4'h8, 2'b10, 1'b1); add_def(6'h0B, 6'h00, K_I, 4'h9, 2'b10, 1'b1);
        add_def(6'h0C, 6'h00, K_I, 4'h4, 2'b10, 1'b0); add_def(6'h0D, 6'h00, K_I, 4'h5, 2'b10, 1'b0);
        add_def(6'h0E, 6'h00, K_I, 4'h6, 2'b10, 1'b0); add_def(6'h0F, 6'h00, K_I, 4'hA, 2'b10, 1'b0);
        add_def(6'h23, 6'h00, K_LW, 4'h1, 2'b10, 1'b1); add_def(6'h2B, 6'h00, K_SW, 4'h1, 2'b10, 1'b1);
        add_def(6'h04, 6'h00, K_BEQ, 4'h3, 2'b00, 1'b0); add_def(6'h05, 6'h00, K_BNE, 4'h3, 2'b00, 1'b0);
        add_def(6'h02, 6'h00, K_J, 4'h0, 2'b00, 1'b0);
        ill[0] = 32'hFC000000; ill[1] = 32'h04000000; ill[2] = 32'h40000000;
        ill[3] = 32'h00221800; ill[4] = 32'h00200008;

        for (int i = 0; i < vt.size(); i++) begin
            do_reset("reset");
            instr = vt[i].ins;
            step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
            step("fetch", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));
            step("decode", 1'b0, 1'b0, 1'b0, o_decode(1'b0));
            step($sformatf("exec_vec%0d", i), 1'b0, vt[i].z, 1'b0, vt[i].exp);
        end

        // ADDU R-type: FETCH, DECODE, EXEC, WB, then back in FETCH on cycle 5
        do_reset("reset");
        instr = 32'h00221821;
        step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        step("addu_fetch", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));
        step("addu_decode", 1'b0, 1'b0, 1'b0, o_decode(1'b0));
        step("addu_exec", 1'b0, 1'b0, 1'b0, mk(4'h1, 2'b00, 1'b0, 1'b0, 2'b00));
        step("addu_wb", 1'b0, 1'b0, 1'b0, o_wb(1'b1, 1'b0));
        step("addu_next_fetch", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));

        // LW with three wait cycles in MEM
        do_reset("reset");
        instr = 32'h8C220008;
        d = defs[find_def(instr)];
        step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        step("lw_fetch", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));
        step("lw_decode", 1'b0, 1'b0, 1'b0, o_decode(1'b0));
        step("lw_exec", 1'b0, 1'b0, 1'b0, o_exec(d, 1'b0));
        for (int k = 0; k < 3; k++) step("lw_mem_wait", 1'b0, 1'b0, 1'b0, o_mem(d));
        step("lw_mem_done", 1'b1, 1'b0, 1'b0, o_mem(d));
        step("lw_wb", 1'b0, 1'b0, 1'b0, o_wb(1'b0, 1'b1));
        step("lw_next_fetch", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));

        // reset asserted in the middle of an SW memory wait
        do_reset("reset");
        instr = 32'hAC220004;
        d = defs[find_def(instr)];
        step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        step("sw_fetch", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));
        step("sw_decode", 1'b0, 1'b0, 1'b0, o_decode(1'b0));
        step("sw_exec", 1'b0, 1'b0, 1'b0, o_exec(d, 1'b0));
        step("sw_mem_wait", 1'b0, 1'b0, 1'b0, o_mem(d));
        mem_ready = 1'b0;
        do_reset("reset_mid_mem");
        step("post_reset_idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        step("post_reset_fetch", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));

        // ADD overflow traps from EXEC, never reaching WB
        do_reset("reset");
        instr = 32'h00221820;
        step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        step("ovf_fetch", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));
        step("ovf_decode", 1'b0, 1'b0, 1'b0, o_decode(1'b0));
        step("ovf_exec", 1'b0, 1'b0, 1'b1, mk(4'h0, 2'b00, 1'b0, 1'b0, 2'b00));
        for (int k = 0; k < 3; k++) step("ovf_trap", 1'b1, 1'b0, 1'b1, o_trap(2'b10));

        // illegal opcode 0x3F
        do_reset("reset");
        instr = 32'hFC000000;
        step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        step("ill_fetch", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));
        step("ill_decode", 1'b0, 1'b0, 1'b0, obs_t'(0));
        for (int k = 0; k < 2; k++) step("ill_trap", 1'b1, 1'b1, 1'b1, o_trap(2'b01));

        // J: PC load in DECODE, straight back to FETCH
        do_reset("reset");
        instr = 32'h08000040;
        step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        step("j_fetch", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));
        step("j_decode", 1'b0, 1'b0, 1'b0, o_decode(1'b1));
        step("j_next_fetch", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));

        // FETCH timeout: count unanswered cycles until trap
        do_reset("reset");
        instr = 32'h00221821;
        step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        mem_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (trap) break;
            cnt++;
            @(posedge clk); #1;
        end
        check_int("tmo_fetch_cycles", cnt, 255);
        check("tmo_trap", act, o_trap(2'b11));
        @(posedge clk); #1;

        // mem_ready on the last allowed cycle wins over the timeout
        do_reset("reset");
        step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        for (int k = 0; k < 254; k++) step("race_wait", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));
        step("race_ready", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));
        step("race_decode", 1'b0, 1'b0, 1'b0, o_decode(1'b0));

        // random instruction streams
        do_reset("reset");
        step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
        for (int n = 0; n < 200; n++) begin
            int idx, wf, wm;
            logic z, of;
            if ($urandom_range(0, 9) == 0) begin
                instr = ill[$urandom_range(0, 4)];
            end else begin
                idx = $urandom_range(0, defs.size() - 1);
                instr = {defs[idx].op, 26'($urandom)};
                if (defs[idx].kind == K_R) instr[5:0] = defs[idx].fn;
            end
            wf = $urandom_range(0, 3);
            for (int k = 0; k < wf; k++)
                step("rnd_fetch_wait", 1'b0, 1'($urandom), 1'($urandom), o_fetch(1'b0));
            step("rnd_fetch", 1'b1, 1'b0, 1'b0, o_fetch(1'b1));
            idx = find_def(instr);
            if (idx < 0) begin
                step("rnd_ill_decode", 1'b0, 1'b0, 1'b0, obs_t'(0));
                step("rnd_ill_trap", 1'b0, 1'b0, 1'b0, o_trap(2'b01));
                do_reset("rnd_reset");
                step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
                continue;
            end
            d = defs[idx];
            step("rnd_decode", 1'b0, 1'b0, 1'b0, o_decode(d.kind == K_J));
            if (d.kind == K_J) continue;
            z  = 1'($urandom);
            of = ($urandom_range(0, 3) == 0);
            step("rnd_exec", 1'b0, z, of, o_exec(d, z));
            if (d.kind == K_BEQ || d.kind == K_BNE) continue;
            if (of && (d.alu == 4'h0 || d.alu == 4'h2)) begin
                step("rnd_ovf_trap", 1'b0, 1'b0, 1'b0, o_trap(2'b10));
                do_reset("rnd_reset");
                step("idle", 1'b0, 1'b0, 1'b0, obs_t'(0));
                continue;
            end
            if (d.kind == K_LW || d.kind == K_SW) begin
                wm = $urandom_range(0, 3);
                for (int k = 0; k < wm; k++) step("rnd_mem_wait", 1'b0, 1'b0, 1'b0, o_mem(d));
                step("rnd_mem", 1'b1, 1'b0, 1'b0, o_mem(d));
                if (d.kind == K_SW) continue;
            end
            step("rnd_wb", 1'b0, 1'b0, 1'b0, o_wb(d.kind == K_R, d.kind == K_LW));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
